if_id_queue: RTL and testbench

Instruction queue between the fetch stage (PC register, instruction memory, PC+4 adder) and the decode stage of the five-stage MIPS pipeline. Buffers up to DEPTH fetched {pc, instr} pairs with valid/ready handshakes on both sides. Fetch keeps running while decode is stalled, and a branch/jump redirect flushes every queued entry. Decode stall becomes `out_ready = 0`; fetch PC enable is driven from `in_ready`.

---
 rtl/if_id_queue_pkg.sv | 17 +
 rtl/queue_storage.sv | 34 +++
 rtl/if_id_queue.sv | 103 ++++++++++
 tb/tb_if_id_queue.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary.
//   RESET_PC     : fetch start address (used by fetch, not by the queue)
//   NOP_INSTR    : sll $0,$0,0, presented to decode when nothing is queued
//   fetch_pair_t : one fetched {pc, instr} pair
package if_id_queue_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_3000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pair_t;

endpackage : if_id_queue_pkg

// File: rtl/queue_storage.sv
// DEPTH x fetch_pair_t register array for the instruction queue.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : pair to store
//   raddr : read address (combinational read)
//   rdata : pair at raddr
// Contents are intentionally not reset; occupancy is tracked by the owner.
module queue_storage
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  fetch_pair_t     wdata,
    input  logic [AW-1:0]   raddr,
    output fetch_pair_t     rdata
);

    fetch_pair_t mem_q [DEPTH];

    // Single write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : queue_storage

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode.
//   clk, reset            : clock, asynchronous active-low reset
//   in_valid/in_ready     : fetch-side handshake; in_pc/in_instr payload
//   out_valid/out_ready   : decode-side handshake; out_pc/out_instr head entry
//   out_pc8               : out_pc + 8 (jal/jalr link value)
//   flush                 : discard all queued entries (redirect)
//   count                 : occupied entries
// Handshakes and data outputs are functions of registered state only.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_pc,
    output logic [31:0]     out_instr,
    output logic [31:0]     out_pc8,
    input  logic            flush,
    output logic [CW-1:0]   count
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic        push;
    logic        pop;
    fetch_pair_t wr_pair;
    fetch_pair_t rd_pair;

    // Handshakes from occupancy only; no bypass in either direction
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != CW'(0));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next-state: flush overrides push/pop; pointers wrap naturally (DEPTH is 2^AW)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_pair.pc    = in_pc;
    assign wr_pair.instr = in_instr;

    queue_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr_q),
        .wdata (wr_pair),
        .raddr (rd_ptr_q),
        .rdata (rd_pair)
    );

    // Empty queue presents a nop at pc 0
    assign out_pc    = out_valid ? rd_pair.pc    : 32'h0;
    assign out_instr = out_valid ? rd_pair.instr : NOP_INSTR;
    assign out_pc8   = out_pc + 32'd8;
    assign count     = count_q;

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH = 4).
module tb_if_id_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc8;
    logic        flush;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    if_id_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_pc8   (out_pc8),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return pc ^ 32'hA500_0000;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins_of(pc);
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic push_n(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] pc);
        check(tag, out_pc, pc);
        check({tag, "_ins"}, out_instr, ins_of(pc));
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset and first fetch
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_instr", out_instr,      32'h0);
        check("rst_out_pc",    out_pc,         32'h0);
        check("rst_out_pc8",   out_pc8,        32'h8);
        check("rst_count",     32'(count),     32'd0);
        reset = 1'b1;
        in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'h3c01_0001;
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc",    out_pc,         32'h3000);
        check("first_pc8",   out_pc8,        32'h3008);
        check("first_instr", out_instr,      32'h3c01_0001);
        check("first_count", 32'(count),     32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("first_empty", 32'(count), 32'd0);

        // Stall fill
        push_n(32'h3000, 4);
        check("fill_count", 32'(count),    32'd4);
        check("fill_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h3010, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("fill_count5", 32'(count), 32'd4);
        check("fill_head",   out_pc,     32'h3000);
        for (int i = 0; i < 4; i++) pop_expect("fill_drain", 32'h3000 + 32'(4 * i));
        check("fill_end_count", 32'(count), 32'd0);

        // Drain order with wrap: push 3, pop 2, push 3, pop all
        push_n(32'h3000, 3);
        check("wrap_c3", 32'(count), 32'd3);
        pop_expect("wrap_p0", 32'h3000);
        pop_expect("wrap_p1", 32'h3004);
        push_n(32'h300c, 3);
        check("wrap_c4", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) pop_expect("wrap_drain", 32'h3008 + 32'(4 * i));
        check("wrap_count0", 32'(count), 32'd0);
        // Pop attempt on empty must not underflow
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("wrap_underflow", 32'(count),     32'd0);
        check("wrap_empty_pc8", out_pc8,        32'h8);

        // Simultaneous push/pop at count 2
        push_n(32'h5000, 2);
        for (int i = 0; i < 10; i++) begin
            check("pp_count", 32'(count), 32'd2);
            check("pp_head",  out_pc,     32'h5000 + 32'(4 * i));
            drive(1'b1, 32'h5008 + 32'(4 * i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("pp_count_end", 32'(count), 32'd2);
        pop_expect("pp_tail0", 32'h5028);
        pop_expect("pp_tail1", 32'h502c);

        // Flush with concurrent push
        push_n(32'h3000, 3);
        drive(1'b1, 32'h3020, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("flush_count", 32'(count),     32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_pc",    out_pc,         32'h0);
        push_n(32'h4000, 1);
        check("flush_head",  out_pc,         32'h4000);
        check("flush_c1",    32'(count),     32'd1);
        pop_expect("flush_pop", 32'h4000);
        check("flush_gone",  32'(count),     32'd0);

        // pc+8 wraps modulo 2^32
        push_n(32'hffff_fffc, 1);
        check("pc8_wrap", out_pc8, 32'h0000_0004);
        pop_expect("pc8_pop", 32'hffff_fffc);

        // Asynchronous reset mid-operation
        push_n(32'h6000, 3);
        check("ar_count_pre", 32'(count), 32'd3);
        #2 reset = 1'b0;
        #1;
        check("ar_valid_now", 32'(out_valid), 32'd0);
        check("ar_count_now", 32'(count),     32'd0);
        check("ar_instr_now", out_instr,      32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("ar_count_post", 32'(count),    32'd0);
        check("ar_ready_post", 32'(in_ready), 32'd1);
        check("ar_pc8_post",   out_pc8,       32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_if_id_queue
